control_unit: RTL and testbench

//   Multi-cycle instruction sequencer and decoder that drives the 8-bit alu from the other side of its interface.
//   - Fetches 32-bit instruction words over a req/valid handshake.
//   - Decodes each word into alu select, register-file read/write addresses, immediate and operand-mux controls.
//   - Issues one register-file write per legal instruction.
//   - Sits between instruction memory and the register file + alu datapath.

---
 rtl/cu_pkg.sv | 24 ++
 rtl/cu_decoder.sv | 33 +++
 rtl/control_unit.sv | 111 +++++++++++
 tb/tb_control_unit.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared opcode, alu-select and state definitions
// for the multi-cycle control unit.
package cu_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  typedef enum logic [1:0] {
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK
  } state_t;

endpackage

// File: rtl/cu_decoder.sv
// Opcode decoder: opcode -> alu select,
// operand-mux controls and legality.
module cu_decoder
  import cu_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [2:0] alu_select,
  output logic       imm_sel,
  output logic       neg_sel,
  output logic       legal
);

  // one-hot style decode of the opcode byte
  always_comb begin
    alu_select = ALU_FWD;
    imm_sel    = 1'b0;
    neg_sel    = 1'b0;
    legal      = 1'b1;
    unique case (1'b1)
      (opcode == OP_LOADI): imm_sel = 1'b1;
      (opcode == OP_MOV):   alu_select = ALU_FWD;
      (opcode == OP_ADD):   alu_select = ALU_ADD;
      (opcode == OP_SUB): begin
        alu_select = ALU_ADD;
        neg_sel    = 1'b1;
      end
      (opcode == OP_AND):   alu_select = ALU_AND;
      (opcode == OP_OR):    alu_select = ALU_OR;
      default:              legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute/writeback
// sequencer driving the alu and register file.
module control_unit
  import cu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter int              REG_AW   = 3,
  parameter int              DATA_W   = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              instr_req,
  output logic [PC_W-1:0]   instr_addr,
  input  logic              instr_valid,
  input  logic [31:0]       instr_data,
  output logic [2:0]        alu_select,
  output logic [REG_AW-1:0] rd_addr1,
  output logic [REG_AW-1:0] rd_addr2,
  output logic [REG_AW-1:0] wr_addr,
  output logic [DATA_W-1:0] imm,
  output logic              imm_sel,
  output logic              neg_sel,
  output logic              wr_en,
  output logic              illegal_op,
  output logic              busy
);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic              legal;
  logic              unused_bits;

  // high bits of the register fields are don't-care
  assign unused_bits = ^{ir_q[23:16+REG_AW],
                         ir_q[15:8+REG_AW]};

  cu_decoder u_dec (
    .opcode     (ir_q[31:24]),
    .alu_select (alu_select),
    .imm_sel    (imm_sel),
    .neg_sel    (neg_sel),
    .legal      (legal)
  );

  assign instr_addr = pc_q;
  assign rd_addr1   = ir_q[8 +: REG_AW];
  assign rd_addr2   = ir_q[0 +: REG_AW];
  assign wr_addr    = ir_q[16 +: REG_AW];
  assign imm        = ir_q[0 +: DATA_W];

  // state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  // pc and instruction register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
      ir_q <= '0;
    end else begin
      pc_q <= pc_d;
      ir_q <= ir_d;
    end
  end

  // next state, pc advance and ir capture
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      FETCH: begin
        if (instr_valid) begin
          ir_d    = instr_data;
          state_d = DECODE;
        end
      end
      DECODE:  state_d = EXECUTE;
      EXECUTE: state_d = WRITEBACK;
      WRITEBACK: begin
        pc_d    = pc_q + PC_W'(4);
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // state-dependent strobes
  always_comb begin
    instr_req  = 1'b0;
    busy       = 1'b1;
    wr_en      = 1'b0;
    illegal_op = 1'b0;
    unique case (state_q)
      FETCH: begin
        instr_req = 1'b1;
        busy      = 1'b0;
      end
      WRITEBACK: begin
        wr_en      = legal;
        illegal_op = ~legal;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed vector bench for control_unit:
// table of instructions plus reset/wrap sequences.
module tb_control_unit;

  logic       clk;
  logic       reset_n;
  logic       instr_req;
  logic [7:0] instr_addr;
  logic       instr_valid;
  logic [31:0] instr_data;
  logic [2:0] alu_select;
  logic [2:0] rd_addr1, rd_addr2, wr_addr;
  logic [7:0] imm;
  logic       imm_sel, neg_sel, wr_en, illegal_op, busy;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] mpc;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  alu;
    logic [2:0]  rd1;
    logic [2:0]  rd2;
    logic [2:0]  wr;
    logic [7:0]  imm;
    logic        isel;
    logic        neg;
    logic        legal;
    int          idle;
    logic        noise;
  } vec_t;

  vec_t tbl[7];

  control_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .instr_req   (instr_req),
    .instr_addr  (instr_addr),
    .instr_valid (instr_valid),
    .instr_data  (instr_data),
    .alu_select  (alu_select),
    .rd_addr1    (rd_addr1),
    .rd_addr2    (rd_addr2),
    .wr_addr     (wr_addr),
    .imm         (imm),
    .imm_sel     (imm_sel),
    .neg_sel     (neg_sel),
    .wr_en       (wr_en),
    .illegal_op  (illegal_op),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  task automatic chk_dec(input vec_t v);
    chk("alu_select", 32'(alu_select), 32'(v.alu));
    chk("rd_addr1", 32'(rd_addr1), 32'(v.rd1));
    chk("rd_addr2", 32'(rd_addr2), 32'(v.rd2));
    chk("wr_addr", 32'(wr_addr), 32'(v.wr));
    chk("imm", 32'(imm), 32'(v.imm));
    chk("imm_sel", 32'(imm_sel), 32'(v.isel));
    chk("neg_sel", 32'(neg_sel), 32'(v.neg));
  endtask

  // Entered #1 after an edge with the DUT in FETCH.
  task automatic do_instr(input vec_t v);
    for (int i = 0; i < v.idle; i++) begin
      instr_valid = 1'b0;
      step();
      chk("idle_req", 32'(instr_req), 32'd1);
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_addr", 32'(instr_addr), 32'(mpc));
    end
    chk("fetch_req", 32'(instr_req), 32'd1);
    chk("fetch_addr", 32'(instr_addr), 32'(mpc));
    chk("fetch_busy", 32'(busy), 32'd0);
    instr_valid = 1'b1;
    instr_data  = v.instr;
    for (int c = 2; c <= 4; c++) begin
      step();
      if (v.noise && c < 4) begin
        instr_valid = 1'b1;
        instr_data  = ~v.instr;
      end else begin
        instr_valid = 1'b0;
        instr_data  = 32'h0;
      end
      chk_dec(v);
      chk("busy", 32'(busy), 32'd1);
      chk("req", 32'(instr_req), 32'd0);
      chk("wr_en", 32'(wr_en),
          32'((c == 4) && v.legal));
      chk("illegal_op", 32'(illegal_op),
          32'((c == 4) && !v.legal));
    end
    instr_valid = 1'b0;
    step();
    mpc = mpc + 8'd4;
    chk("next_addr", 32'(instr_addr), 32'(mpc));
    chk("next_req", 32'(instr_req), 32'd1);
    chk("next_wr_en", 32'(wr_en), 32'd0);
  endtask

  initial begin
    vec_t filler;
    vec_t ill;
    vec_t orv;
    tbl[0] = '{32'h02030102, 3'd1, 3'd1, 3'd2, 3'd3,
               8'h02, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    tbl[1] = '{32'h0005007F, 3'd0, 3'd0, 3'd7, 3'd5,
               8'h7F, 1'b1, 1'b0, 1'b1, 0, 1'b0};
    tbl[2] = '{32'h03060505, 3'd1, 3'd5, 3'd5, 3'd6,
               8'h05, 1'b0, 1'b1, 1'b1, 0, 1'b0};
    tbl[3] = '{32'h04FF0A0B, 3'd2, 3'd2, 3'd3, 3'd7,
               8'h0B, 1'b0, 1'b0, 1'b1, 2, 1'b0};
    tbl[4] = '{32'h05010203, 3'd3, 3'd2, 3'd3, 3'd1,
               8'h03, 1'b0, 1'b0, 1'b1, 0, 1'b1};
    tbl[5] = '{32'h01020406, 3'd0, 3'd4, 3'd6, 3'd2,
               8'h06, 1'b0, 1'b0, 1'b1, 0, 1'b0};
    tbl[6] = '{32'h06112233, 3'd0, 3'd2, 3'd3, 3'd1,
               8'h33, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    filler = '{32'h00010044, 3'd0, 3'd0, 3'd4, 3'd1,
               8'h44, 1'b1, 1'b0, 1'b1, 0, 1'b0};
    ill    = '{32'hFF000000, 3'd0, 3'd0, 3'd0, 3'd0,
               8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0};
    orv    = '{32'h05040203, 3'd3, 3'd2, 3'd3, 3'd4,
               8'h03, 1'b0, 1'b0, 1'b1, 0, 1'b0};

    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instr_data  = 32'h0;
    mpc         = 8'h00;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    chk("rst_addr", 32'(instr_addr), 32'd0);
    chk("rst_alu", 32'(alu_select), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_req", 32'(instr_req), 32'd1);
      chk("wait_addr", 32'(instr_addr), 32'd0);
      chk("wait_busy", 32'(busy), 32'd0);
      chk("wait_wr_en", 32'(wr_en), 32'd0);
    end

    for (int k = 0; k < 7; k++) do_instr(tbl[k]);

    while (mpc != 8'hFC) do_instr(filler);
    do_instr(ill);
    chk("wrap_addr", 32'(instr_addr), 32'h00);

    instr_valid = 1'b1;
    instr_data  = orv.instr;
    step();
    instr_valid = 1'b0;
    chk_dec(orv);
    step();
    chk("exec_busy", 32'(busy), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
    chk("mid_rst_alu", 32'(alu_select), 32'd0);
    chk("mid_rst_wr_addr", 32'(wr_addr), 32'd0);
    chk("mid_rst_addr", 32'(instr_addr), 32'd0);
    step();
    chk("held_rst_wr_en", 32'(wr_en), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    chk("restart_req", 32'(instr_req), 32'd1);
    chk("restart_addr", 32'(instr_addr), 32'd0);
    chk("restart_wr_en", 32'(wr_en), 32'd0);
    mpc = 8'h00;
    do_instr(tbl[0]);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
